iob_pattern_gen: RTL and testbench
==================================

// Module: iob_pattern_gen
// PURPOSE
//  Pattern generator: the drive-side counterpart of the logic analyser. The CPU loads a sample buffer
//  over the native slave interface; on start the block replays the samples onto signal_out at a
//  programmable rate, either once or looping. Used to stimulate DUT logic that the ILA then captures.
// PARAMETERS
//  ADDR_W    4   CPU word-address width
//  DATA_W    32  CPU data width
//  SIGNAL_W  32  width of signal_out (<= DATA_W; wider wdata bits are dropped)
//  BUFFER_W  10  log2 of buffer depth (depth = 2**BUFFER_W samples)
// PORTS
//  clk         in   1         system clock; single clock domain
//  rst         in   1         asynchronous, active-high reset
//  valid       in   1         CPU request valid
//  address     in   ADDR_W    CPU word address
//  wdata       in   DATA_W    CPU write data
//  wstrb       in   DATA_W/8  write strobes; any bit set = write, all zero = read
//  rdata       out  DATA_W    read data, valid while ready=1
//  ready       out  1         one-cycle pulse completing the request
//  trigger_in  in   1         external start trigger (only with PATGEN_EXT_TRIGGER_EN)
//  signal_out  out  SIGNAL_W  generated pattern, registered
//  playing     out  1         1 while in PLAY
//  done        out  1         1 while in DONE
// BEHAVIOUR
//  Reset: signal_out=0, rdata=0, ready=0, playing=0, done=0, all registers 0, FSM=IDLE. Buffer not cleared.
//  Bus: ready pulses 1 cycle after valid is sampled with ready=0; a write takes effect on the edge that raises ready.
//  Register map (word addr): 0 CTRL W: b0 start, b1 stop, b2 loop (loop is stored; start/stop self-clear)
//   1 STATUS R: b0 playing, b1 done, b2 armed | 2 DIVIDER R/W 16b | 3 LENGTH R/W BUFFER_W+1 bits,
//   clamped to 2**BUFFER_W | 4 INDEX R/W BUFFER_W bits | 5 DATA W: buf[INDEX]<=wdata, INDEX++ (wraps mod 2**BUFFER_W)
//   Reads of 0, 5 and unmapped addresses return 0.
//  FSM: IDLE -start-> PLAY (ARMED when trigger enabled) ; PLAY -last sample period ends, loop=0-> DONE
//   PLAY -loop=1-> stays in PLAY, pointer wraps to 0 with no gap ; DONE -start-> PLAY ; any -stop-> IDLE
//  Timing: start accepted at edge E0 -> signal_out=buf[0] from edge E0+2; each sample held DIVIDER+1 cycles;
//   sample k appears at E0+2+k*(DIVIDER+1). DONE entered at the end of the last sample's period.
//  signal_out holds its last value in DONE and after stop; it changes only in PLAY.
//  Boundaries: LENGTH=0 -> start goes directly to DONE, signal_out unchanged.
//   LENGTH=1 with loop -> buf[0] held indefinitely.
//   start while PLAY/ARMED ignored; start+stop in the same write -> stop wins (IDLE).
//   Writes to DATA/INDEX/DIVIDER/LENGTH while PLAY/ARMED ignored (no side effects); CTRL loop bit writable anytime.
//   Clearing loop during PLAY -> finishes the current pass, then DONE.
//   Reset mid-play -> immediate IDLE, outputs to reset values.
//  Buffer read latency 1 cycle; the pipeline prefetches so DIVIDER=0 yields a new sample every cycle.
// CONFIGURATION
//  PATGEN_EXT_TRIGGER_EN defined: trigger_in port present; start moves IDLE->ARMED (STATUS b2=1).
//   The first clk edge sampling trigger_in=1 in ARMED is E0 for the timing rule above.
//   Stop in ARMED -> IDLE. A trigger high at the moment start is accepted is not counted; it is sampled from the next cycle.
//  Not defined: no trigger_in port, no ARMED state, STATUS b2 reads 0; start goes straight to PLAY.
// TESTING
//  Write DATA 0xA,0xB,0xC from INDEX 0, LENGTH=3, DIVIDER=0, start -> signal_out A,B,C on E0+2..E0+4; done=1 at E0+5.
//  Same buffer, DIVIDER=3, loop=1 -> each value held 4 cycles, sequence A,B,C,A,B... with no gap; stop -> IDLE, hold value.
//  LENGTH=0, start -> done=1 on the next cycle, signal_out unchanged, playing never 1.
//  Set INDEX=2**BUFFER_W-1, write DATA twice -> second lands at buf[0]; INDEX reads 1.
//  During PLAY, write DATA/LENGTH -> readback unchanged; CTRL start|stop -> IDLE; assert rst mid-play -> all outputs 0.
//  PATGEN_EXT_TRIGGER_EN: start -> STATUS=0x4, signal_out static for 20 cycles; trigger_in=1 -> first sample 2 cycles later.

Source files
------------

// File: rtl/iob_pattern_gen.sv
// Pattern generator: CPU fills a sample buffer over the native slave bus, then the
// samples are replayed on signal_out at DIVIDER+1 cycles each, once or looping.
// Optional external start trigger: define PATGEN_EXT_TRIGGER_EN.
module iob_pattern_gen #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int SIGNAL_W = 32,
    parameter int BUFFER_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
`ifdef PATGEN_EXT_TRIGGER_EN
    input  logic                  trigger_in,
`endif
    output logic [SIGNAL_W-1:0]   signal_out,
    output logic                  playing,
    output logic                  done
);

    localparam int DEPTH = 2**BUFFER_W;
    localparam int LEN_W = BUFFER_W + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_DIVIDER = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_LENGTH  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_INDEX   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_DATA    = ADDR_W'(5);

`ifdef PATGEN_EXT_TRIGGER_EN
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE, S_ARMED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;
`endif

    state_t state, state_nxt;

    logic                  loop;
    logic [15:0]           divider;
    logic [LEN_W-1:0]      length;
    logic [BUFFER_W-1:0]   index;
    logic [15:0]           cnt;
    logic                  shown;
    logic [BUFFER_W-1:0]   fptr, fptr_nxt;
    logic [SIGNAL_W-1:0]   mem [DEPTH];
    logic [SIGNAL_W-1:0]   mem_q;

    logic accept, wr, rd, busy, cfg_wr, ctrl_wr, start_req, stop_req;
    logic armed, go, start_play, load;
    logic [DATA_W-1:0] rd_val;
    logic [LEN_W-1:0]  wr_len;

    assign playing = (state == S_PLAY);
    assign done    = (state == S_DONE);
`ifdef PATGEN_EXT_TRIGGER_EN
    assign armed   = (state == S_ARMED);
`else
    assign armed   = 1'b0;
`endif

    assign accept    = valid & ~ready;
    assign wr        = accept & (|wstrb);
    assign rd        = accept & ~(|wstrb);
    assign busy      = playing | armed;
    assign cfg_wr    = wr & ~busy;
    assign ctrl_wr   = wr & (address == A_CTRL);
    assign start_req = ctrl_wr & wdata[0];
    assign stop_req  = ctrl_wr & wdata[1];
    assign wr_len    = (wdata > DATA_W'(DEPTH)) ? LEN_MAX : wdata[LEN_W-1:0];

    always_comb begin
        rd_val = '0;
        case (address)
            A_STATUS:  rd_val = DATA_W'({armed, done, playing});
            A_DIVIDER: rd_val = DATA_W'(divider);
            A_LENGTH:  rd_val = DATA_W'(length);
            A_INDEX:   rd_val = DATA_W'(index);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready   <= 1'b0;
            rdata   <= '0;
            loop    <= 1'b0;
            divider <= '0;
            length  <= '0;
            index   <= '0;
        end else begin
            ready <= accept;
            rdata <= rd ? rd_val : '0;
            if (ctrl_wr) loop <= wdata[2];
            if (cfg_wr) begin
                case (address)
                    A_DIVIDER: divider <= wdata[15:0];
                    A_LENGTH:  length  <= wr_len;
                    A_INDEX:   index   <= wdata[BUFFER_W-1:0];
                    A_DATA:    index   <= index + 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    // Buffer has no reset; read port tracks the next fetch pointer so mem_q == buf[fptr]
    always_ff @(posedge clk) begin
        if (cfg_wr && address == A_DATA) mem[index] <= wdata[SIGNAL_W-1:0];
        mem_q <= mem[fptr_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        go         = 1'b0;
        start_play = 1'b0;
        load       = 1'b0;
        if (stop_req) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
`ifdef PATGEN_EXT_TRIGGER_EN
                    if (start_req) state_nxt = S_ARMED;
`else
                    go = start_req;
`endif
                end
`ifdef PATGEN_EXT_TRIGGER_EN
                S_ARMED: go = trigger_in;
`endif
                S_PLAY: begin
                    // fptr back at 0 after a shown sample means the last sample's period just ended
                    if (cnt == '0) begin
                        if (shown && fptr == '0 && !loop) state_nxt = S_DONE;
                        else                              load = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            if (go) begin
                if (length == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt  = S_PLAY;
                    start_play = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fptr_nxt = fptr;
        if (start_play)
            fptr_nxt = '0;
        else if (load)
            fptr_nxt = ({1'b0, fptr} == length - 1'b1) ? '0 : fptr + 1'b1;
    end

    // cnt starts at 1 so the first sample lands two edges after start (one for the buffer read)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            shown      <= 1'b0;
            fptr       <= '0;
            signal_out <= '0;
        end else begin
            fptr <= fptr_nxt;
            if (start_play) begin
                cnt   <= 16'd1;
                shown <= 1'b0;
            end else if (load) begin
                cnt        <= divider;
                shown      <= 1'b1;
                signal_out <= mem_q;
            end else if (playing && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_pattern_gen.sv
// Self-checking bench for iob_pattern_gen: register vector table plus directed
// playback sequences (single pass, looping, zero length, busy writes, reset mid-play).
module tb_iob_pattern_gen;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int SIGNAL_W = 32;
    localparam int BUFFER_W = 10;

    localparam logic [3:0] A_CTRL = 4'd0, A_STATUS = 4'd1, A_DIVIDER = 4'd2;
    localparam logic [3:0] A_LENGTH = 4'd3, A_INDEX = 4'd4, A_DATA = 4'd5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid = 1'b0;
    logic [ADDR_W-1:0]   address = '0;
    logic [DATA_W-1:0]   wdata = '0;
    logic [DATA_W/8-1:0] wstrb = '0;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic [SIGNAL_W-1:0] signal_out;
    logic                playing;
    logic                done;
`ifdef PATGEN_EXT_TRIGGER_EN
    logic                trigger_in = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    iob_pattern_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIGNAL_W(SIGNAL_W), .BUFFER_W(BUFFER_W)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready),
`ifdef PATGEN_EXT_TRIGGER_EN
        .trigger_in(trigger_in),
`endif
        .signal_out(signal_out), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];
    logic [31:0] pat[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at 1ns after the edge that raised ready (the edge where a write takes effect)
    task automatic bus_xfer(input logic is_wr, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
        int n;
        @(negedge clk);
        valid   = 1'b1;
        address = a;
        wdata   = d;
        wstrb   = is_wr ? '1 : '0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 8);
        rd = rdata;
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: ready=0 after %0d cycles, expected 1", n);
        end
        valid = 1'b0;
        wstrb = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_xfer(1'b0, a, d, d);
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] exp;

        pat[0] = 32'hA;
        pat[1] = 32'hB;
        pat[2] = 32'hC;

        vecs[0]  = '{1'b0, A_STATUS,  32'h0,       32'h0,   "status_idle"};
        vecs[1]  = '{1'b1, A_DIVIDER, 32'h0001_2345, 32'h0, "div_wr"};
        vecs[2]  = '{1'b0, A_DIVIDER, 32'h0,       32'h2345, "div_16b"};
        vecs[3]  = '{1'b1, A_LENGTH,  32'h7FF,     32'h0,   "len_wr_big"};
        vecs[4]  = '{1'b0, A_LENGTH,  32'h0,       32'h400, "len_clamp"};
        vecs[5]  = '{1'b1, A_LENGTH,  32'h5,       32'h0,   "len_wr"};
        vecs[6]  = '{1'b0, A_LENGTH,  32'h0,       32'h5,   "len_rd"};
        vecs[7]  = '{1'b1, A_INDEX,   32'h405,     32'h0,   "idx_wr"};
        vecs[8]  = '{1'b0, A_INDEX,   32'h0,       32'h5,   "idx_trunc"};
        vecs[9]  = '{1'b1, A_CTRL,    32'h4,       32'h0,   "ctrl_loop"};
        vecs[10] = '{1'b0, A_CTRL,    32'h0,       32'h0,   "ctrl_rd_zero"};
        vecs[11] = '{1'b0, A_STATUS,  32'h0,       32'h0,   "status_loop"};
        vecs[12] = '{1'b0, A_DATA,    32'h0,       32'h0,   "data_rd_zero"};
        vecs[13] = '{1'b0, 4'd9,      32'h0,       32'h0,   "unmapped_zero"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_signal_out", signal_out, 32'h0);
        check("rst_playing", {31'h0, playing}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Register map
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rv);
                check(vecs[i].name, rv, vecs[i].exp);
            end
        end

        // INDEX wraps: second DATA lands at buf[0]; replay it with LENGTH=1
        bus_write(A_INDEX, 32'h3FF);
        bus_write(A_DATA, 32'h11);
        bus_write(A_DATA, 32'h22);
        bus_read(A_INDEX, rv);
        check("idx_wrap", rv, 32'h1);
        bus_write(A_DIVIDER, 32'h0);
        bus_write(A_LENGTH, 32'h1);
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("wrap_buf0", signal_out, 32'h22);
        @(posedge clk);
        #1;
        check("len1_done", {31'h0, done}, 32'h1);

        // Single pass A,B,C with DIVIDER=0
        bus_write(A_INDEX, 32'h0);
        for (int i = 0; i < 3; i++) bus_write(A_DATA, pat[i]);
        bus_write(A_LENGTH, 32'h3);
        bus_write(A_CTRL, 32'h1);
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk);
            #1;
            exp = (j < 2) ? 32'h22 : pat[(j < 5) ? j - 2 : 2];
            check($sformatf("once_out_e%0d", j), signal_out, exp);
            check($sformatf("once_playing_e%0d", j), {31'h0, playing}, (j < 5) ? 32'h1 : 32'h0);
            check($sformatf("once_done_e%0d", j), {31'h0, done}, (j == 5) ? 32'h1 : 32'h0);
        end
        bus_read(A_STATUS, rv);
        check("status_done", rv, 32'h2);

        // Looping, DIVIDER=3: every value held 4 cycles, no gap at wrap
        bus_write(A_DIVIDER, 32'h3);
        bus_write(A_CTRL, 32'h5);
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            exp = (j < 2) ? 32'hC : pat[((j - 2) / 4) % 3];
            check($sformatf("loop_out_e%0d", j), signal_out, exp);
        end
        bus_write(A_CTRL, 32'h2);
        check("stop_playing", {31'h0, playing}, 32'h0);
        check("stop_done", {31'h0, done}, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("stop_hold", signal_out, 32'hB);

        // LENGTH=0: straight to DONE, output unchanged
        bus_write(A_LENGTH, 32'h0);
        bus_write(A_CTRL, 32'h1);
        check("len0_done", {31'h0, done}, 32'h1);
        check("len0_playing", {31'h0, playing}, 32'h0);
        check("len0_out", signal_out, 32'hB);
        bus_read(A_STATUS, rv);
        check("len0_status", rv, 32'h2);

        // Config writes ignored while playing; start ignored; start|stop stops
        bus_write(A_LENGTH, 32'h3);
        bus_write(A_DIVIDER, 32'd100);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_DATA, 32'h55);
        bus_write(A_LENGTH, 32'h9);
        bus_write(A_INDEX, 32'h7);
        bus_write(A_DIVIDER, 32'h5);
        bus_read(A_LENGTH, rv);
        check("busy_len", rv, 32'h3);
        bus_read(A_INDEX, rv);
        check("busy_idx", rv, 32'h3);
        bus_read(A_DIVIDER, rv);
        check("busy_div", rv, 32'd100);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, rv);
        check("busy_status", rv, 32'h1);
        check("busy_out", signal_out, 32'hA);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_STATUS, rv);
        check("startstop_status", rv, 32'h0);

        // Reset mid-play
        bus_write(A_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_out", signal_out, 32'hA);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", signal_out, 32'h0);
        check("midrst_playing", {31'h0, playing}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_ready", {31'h0, ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_DIVIDER, rv);
        check("midrst_div", rv, 32'h0);
        bus_read(A_STATUS, rv);
        check("midrst_status", rv, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
